// File: rtl/msg_framer_if.sv
// msg_framer_if: request handshake plus framed beat stream between a message source and the framer
interface msg_framer_if #(parameter int LEN_W = 4);
  logic             req_valid;
  logic [LEN_W-1:0] req_len;
  logic             req_ready;
  logic             abort;
  logic             valid;
  logic             head;
  logic             tail;
  logic [LEN_W-1:0] beat_cnt;
  modport master (output req_valid, req_len, abort, input req_ready, valid, head, tail, beat_cnt);
  modport slave (input req_valid, req_len, abort, output req_ready, valid, head, tail, beat_cnt);
endinterface

// File: rtl/msg_framer.sv
// msg_framer: frames length-tagged requests into valid/head/tail beats with an idle gap; MSG_FRAMER_ABORT_CNT_EN adds abort_count
module msg_framer #(
  parameter int LEN_W = 4,
  parameter int GAP = 2
) (
  input  logic       clock,
  input  logic       reset,
  msg_framer_if.slave bus,
  output logic       busy,
  output logic [7:0] msg_count
`ifdef MSG_FRAMER_ABORT_CNT_EN
  , output logic [7:0] abort_count
`endif
);
  localparam int GAP_N = GAP < 1 ? 1 : GAP;
  localparam int GW = $clog2(GAP_N + 1);
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
  state_t state, state_n;
  logic [LEN_W-1:0] len_q, len_n, beat_n;
  logic [GW-1:0] gap_q, gap_n;
  logic valid_n, head_n, tail_n, last, done;
  assign last = bus.beat_cnt == len_q - 1'b1;
  assign bus.req_ready = state == S_IDLE;
  assign busy = state != S_IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      len_q <= '0;
      gap_q <= '0;
      bus.valid <= 1'b0;
      bus.head <= 1'b0;
      bus.tail <= 1'b0;
      bus.beat_cnt <= '0;
      msg_count <= '0;
    end else begin
      state <= state_n;
      len_q <= len_n;
      gap_q <= gap_n;
      bus.valid <= valid_n;
      bus.head <= head_n;
      bus.tail <= tail_n;
      bus.beat_cnt <= beat_n;
      msg_count <= msg_count + 8'(done);
    end
  end
  always_comb begin
    state_n = (state == S_IDLE) ? (bus.req_valid ? S_SEND : S_IDLE)
            : (state == S_SEND) ? ((bus.abort || last) ? S_GAP : S_SEND)
            : (gap_q == GW'(GAP_N - 1)) ? S_IDLE : S_GAP;
  end
  // Outputs are computed from the next state so they register alongside it.
  always_comb begin
    done = state == S_SEND && !bus.abort && last;
    len_n = (state == S_IDLE && bus.req_valid) ? (bus.req_len == '0 ? LEN_W'(1) : bus.req_len) : len_q;
    beat_n = (state == S_SEND && state_n == S_SEND) ? bus.beat_cnt + 1'b1 : '0;
    gap_n = (state == S_GAP) ? gap_q + 1'b1 : '0;
    valid_n = state_n == S_SEND;
    head_n = valid_n && beat_n == '0;
    tail_n = valid_n && beat_n == len_n - 1'b1;
  end
`ifdef MSG_FRAMER_ABORT_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) abort_count <= '0;
    else abort_count <= abort_count + 8'(state == S_SEND && bus.abort);
  end
`endif
endmodule

// File: tb/tb_msg_framer.sv
// tb_msg_framer: randomized scoreboard bench for msg_framer against a cycle-level message model
module tb_msg_framer;
  localparam int LEN_W = 4;
  localparam int GAP = 2;
  localparam int GAP_N = GAP < 1 ? 1 : GAP;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy;
  logic [7:0] msg_count;
`ifdef MSG_FRAMER_ABORT_CNT_EN
  logic [7:0] abort_count;
`endif
  msg_framer_if #(.LEN_W(LEN_W)) bus ();

  msg_framer #(.LEN_W(LEN_W), .GAP(GAP)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .msg_count(msg_count)
`ifdef MSG_FRAMER_ABORT_CNT_EN
    , .abort_count(abort_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int cyc;
    int beat;
    int head;
    int tail;
    int msgc;
    int abc;
  } beat_t;

  beat_t q[$];
  int checks = 0;
  int errors = 0;
  int n = 0;
  int mcyc = 0;
  int next_free = 0;
  logic [7:0] exp_msgs = '0;
  logic [7:0] exp_aborts = '0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, mcyc, act, exp);
    end
  endtask

  task automatic go_to(input int c);
    while (n < c) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, int'(bus.valid), 0);
    chk({tag, "_head"}, int'(bus.head), 0);
    chk({tag, "_tail"}, int'(bus.tail), 0);
    chk({tag, "_beat_cnt"}, int'(bus.beat_cnt), 0);
    chk({tag, "_msg_count"}, int'(msg_count), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_req_ready"}, int'(bus.req_ready), 1);
  endtask

  // One message: request raised d cycles from now, accepted when the framer is next idle,
  // optionally aborted on beat ab; every expected beat is queued at acceptance.
  task automatic send_msg(input int d, input int len, input int ab, input bit stray);
    int a, le, nb;
    beat_t b;
    go_to(n + d);
    bus.req_valid = 1'b1;
    bus.req_len = LEN_W'(len);
    a = (n > next_free) ? n : next_free;
    le = (len == 0) ? 1 : len;
    nb = (ab >= 0) ? ab + 1 : le;
    go_to(a);
    chk("req_ready_at_accept", int'(bus.req_ready), 1);
    if (stray) bus.abort = 1'b1;
    for (int k = 0; k < nb; k++) begin
      b.cyc = a + 1 + k;
      b.beat = k;
      b.head = (k == 0);
      b.tail = (k == le - 1);
      b.msgc = exp_msgs;
      b.abc = exp_aborts;
      q.push_back(b);
    end
    go_to(a + 1);
    bus.req_valid = 1'b0;
    bus.abort = 1'b0;
    bus.req_len = LEN_W'($urandom);
    if (ab >= 0) begin
      go_to(a + 1 + ab);
      bus.abort = 1'b1;
      go_to(a + 2 + ab);
      bus.abort = 1'b0;
    end
    next_free = a + nb + GAP_N + 1;
    if (ab >= 0) exp_aborts++;
    else exp_msgs++;
  endtask

  always @(posedge clock) mcyc <= mcyc + 1;

  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc < mcyc) begin
      chk("missing_beat", q[0].cyc, mcyc);
      void'(q.pop_front());
    end
    if (bus.valid === 1'b1) begin
      if (q.size() == 0 || q[0].cyc != mcyc) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        beat_t e;
        e = q.pop_front();
        chk("beat_cnt", int'(bus.beat_cnt), e.beat);
        chk("head", int'(bus.head), e.head);
        chk("tail", int'(bus.tail), e.tail);
        chk("busy", int'(busy), 1);
        chk("msg_count", int'(msg_count), e.msgc);
`ifdef MSG_FRAMER_ABORT_CNT_EN
        chk("abort_count", int'(abort_count), e.abc);
`endif
      end
    end
  end

  initial begin
    int a, le;
    beat_t b;
    bus.req_valid = 1'b1;
    bus.req_len = LEN_W'(3);
    bus.abort = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      go_to(c);
      if (c == 3) reset = 1'b0;
      chk_idle("reset");
    end
    next_free = 3;
    send_msg(0, 3, -1, 1'b0);
    send_msg(0, 1, -1, 1'b0);
    send_msg(0, 4, -1, 1'b1);
    send_msg(0, 4, -1, 1'b0);
    send_msg(2, 0, -1, 1'b0);
    send_msg(1, 5, 2, 1'b0);
    send_msg(0, 3, 2, 1'b0);
    send_msg(0, 15, -1, 1'b0);
    for (int i = 0; i < 150; i++) begin
      int d, len, ab;
      d = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      len = $urandom_range(0, 15);
      le = (len == 0) ? 1 : len;
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, le - 1) : -1;
      send_msg(d, len, ab, $urandom_range(0, 3) == 0);
    end
    // Reset landing on beat 1 of a four-beat message.
    go_to(next_free);
    a = n;
    bus.req_valid = 1'b1;
    bus.req_len = LEN_W'(4);
    for (int k = 0; k < 2; k++) begin
      b.cyc = a + 1 + k;
      b.beat = k;
      b.head = (k == 0);
      b.tail = 0;
      b.msgc = exp_msgs;
      b.abc = exp_aborts;
      q.push_back(b);
    end
    go_to(a + 1);
    bus.req_valid = 1'b0;
    go_to(a + 2);
    reset = 1'b1;
    go_to(a + 3);
    reset = 1'b0;
    chk_idle("mid_reset");
    exp_msgs = '0;
    exp_aborts = '0;
    next_free = a + 3;
    for (int i = 0; i < 257; i++) send_msg(0, 1, -1, 1'b0);
    go_to(next_free + 2);
    chk("wrap_msg_count", int'(msg_count), int'(exp_msgs));
    chk("wrap_msg_count_is_1", int'(exp_msgs), int'(msg_count) == 1 ? 1 : 1000);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
